lane_seg_mul_arbiter: RTL and testbench

- Shares one signed 16x6 -> 22 multiplier among N_REQ requesters in the lane-segmentation datapath, e.g. the per-tap weight multiplies of parallel filter lanes.
- Grants one request per cycle by round-robin and registers the operands.
- Computes through a combinational multiplier core, registers the product, and returns it tagged to the originating requester.
- Fixed issue-to-response latency of 2 cycles; freezes on a clock-enable.

---
 rtl/lane_seg_mul_pkg.sv | 18 +
 rtl/lane_seg_mul_arbiter_mul.sv | 19 +
 rtl/lane_seg_mul_arbiter.sv | 119 +++++++++++
 tb/tb_lane_seg_mul_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lane_seg_mul_pkg.sv
// Shared widths and helpers for the lane-segmentation shared multiplier.
// Defaults match the 16s x 6s -> 22 filter-tap multiply.
package lane_seg_mul_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int A_W_DEF   = 16;
  localparam int B_W_DEF   = 6;
  localparam int P_W_DEF   = 22;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lane_seg_mul_arbiter_mul.sv
// Combinational signed A x B multiplier core; full-width product, no rounding.
module lane_seg_mul_arbiter_mul #(
  parameter int A_W = 16,
  parameter int B_W = 6,
  parameter int P_W = 22
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;

  assign a_ext = P_W'(a);
  assign b_ext = P_W'(b);
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/lane_seg_mul_arbiter.sv
// Round-robin arbiter feeding one shared signed multiplier; 2-cycle issue-to-
// response latency, tagged one-hot response, whole block frozen by ap_ce.
module lane_seg_mul_arbiter
  import lane_seg_mul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int P_W   = P_W_DEF
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   ap_ce,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [P_W-1:0]         rsp_data,
  output logic                   busy
);

  localparam int TAG_W  = clog2(N_REQ);
  localparam int STAGES = 2;

  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [A_W-1:0]    s1_a_q, s1_a_d;
  logic [B_W-1:0]    s1_b_q, s1_b_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [P_W-1:0]    s2_p_q, s2_p_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

  logic [N_REQ-1:0]  grant_oh;
  logic [TAG_W-1:0]  gidx;
  logic              xfer;
  logic signed [P_W-1:0] mul_p;

  // First valid at or after ptr, wrapping; ready never depends on operands.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [TAG_W-1:0] ptr);
    logic found;
    int   idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && v[idx]) begin
        rr_pick[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

  always_comb begin
    grant_oh = rr_pick(req_valid, ptr_q);
    gidx     = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant_oh[i]) gidx = TAG_W'(i);
  end

  assign req_ready = (ap_ce && !ap_rst) ? grant_oh : '0;
  assign xfer      = |req_ready;

  always_comb begin
    ptr_d      = ptr_q;
    vld_pipe_d = vld_pipe_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_p_d     = s2_p_q;
    s2_tag_d   = s2_tag_q;
    if (ap_ce) begin
      vld_pipe_d = {vld_pipe_q[1], xfer};
      if (xfer) begin
        s1_a_d   = req_a[gidx*A_W +: A_W];
        s1_b_d   = req_b[gidx*B_W +: B_W];
        s1_tag_d = gidx;
        ptr_d    = (gidx == TAG_W'(N_REQ-1)) ? '0 : gidx + TAG_W'(1);
      end
      // Product only reloads behind a live operand so rsp_data holds when idle.
      if (vld_pipe_q[1]) begin
        s2_p_d   = mul_p;
        s2_tag_d = s1_tag_q;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_p_q     <= '0;
      s2_tag_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      vld_pipe_q <= vld_pipe_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_p_q     <= s2_p_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  lane_seg_mul_arbiter_mul #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (mul_p)
  );

  assign rsp_valid = vld_pipe_q[STAGES] ? ({{(N_REQ-1){1'b0}}, 1'b1} << s2_tag_q) : '0;
  assign rsp_data  = s2_p_q;
  assign busy      = |vld_pipe_q;

endmodule

// File: tb/tb_lane_seg_mul_arbiter.sv
// Directed bench for lane_seg_mul_arbiter with hand-computed expectations.
module tb_lane_seg_mul_arbiter;

  localparam int N = 4;
  localparam int AW = 16;
  localparam int BW = 6;
  localparam int PW = 22;

  logic            ap_clk, ap_rst, ap_ce;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [PW-1:0]   rsp_data;
  logic            busy;

  int total = 0;
  int bad   = 0;

  lane_seg_mul_arbiter dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
  endtask

  logic [AW-1:0] xa [3];
  logic [BW-1:0] xb [3];
  logic [PW-1:0] xp [3];

  initial begin
    ap_rst = 1'b1; ap_ce = 1'b1;
    req_valid = '1; req_a = '0; req_b = '0;
    #1;
    chk("rst_ready_forced0", 32'(req_ready), 32'h0);
    tick();
    tick();
    req_valid = '0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    ap_rst = 1'b0;

    // single request from requester 2
    set_req(2, -16'sd3, 6'sd5);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("single_s1_busy", 32'(busy), 32'h1);
    chk("single_s1_norsp", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_data", 32'(rsp_data), 32'h3FFFF1);
    chk("single_s2_busy", 32'(busy), 32'h1);
    tick();
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_idle_rsp", 32'(rsp_valid), 32'h0);
    chk("single_data_hold", 32'(rsp_data), 32'h3FFFF1);

    // full contention from rr_ptr=0
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 6'sd2);
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) chk($sformatf("cont_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("cont_rspv_%0d", k), 32'(rsp_valid), 32'(1 << ((k - 2) % 4)));
        chk($sformatf("cont_rspd_%0d", k), 32'(rsp_data), 32'(2 * ((k - 2) % 4 + 1)));
      end
      tick();
    end
    req_valid = '0;

    // extremes, back to back on requester 0 (ptr wraps back to 0 each time)
    xa[0] = 16'h8000; xb[0] = 6'h20; xp[0] = 22'h100000;
    xa[1] = 16'h7FFF; xb[1] = 6'h1F; xp[1] = 22'd1015777;
    xa[2] = 16'h8000; xb[2] = 6'h1F; xp[2] = 22'h308000;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        set_req(0, xa[k], xb[k]);
        req_valid = 4'b0001;
      end else req_valid = '0;
      #1;
      if (k < 3) chk($sformatf("ext_ready_%0d", k), 32'(req_ready), 32'h1);
      if (k >= 2) begin
        chk($sformatf("ext_rspv_%0d", k - 2), 32'(rsp_valid), 32'h1);
        chk($sformatf("ext_rspd_%0d", k - 2), 32'(rsp_data), 32'(xp[k - 2]));
      end
      tick();
    end
    tick();

    // skip without bubble: rr_ptr=1, only requester 3 valid
    set_req(3, 16'sd4, 6'sd4);
    req_valid = 4'b1000;
    #1;
    chk("skip_ready3", 32'(req_ready), 32'h8);
    tick();
    set_req(0, 16'sd1, 6'sd1);
    req_valid = 4'b1001;
    #1;
    chk("skip_ptr0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("skip_rspv3", 32'(rsp_valid), 32'h8);
    chk("skip_rspd3", 32'(rsp_data), 32'd16);
    tick();
    tick();

    // freeze: ptr=1, transfer requester 1 at cycle t, freeze t+1..t+3
    set_req(1, 16'sd7, 6'sd3);
    set_req(2, 16'sd5, -6'sd1);
    req_valid = 4'b0010;
    #1;
    chk("frz_ready_t", 32'(req_ready), 32'h2);
    tick();
    ap_ce = 1'b0;
    req_valid = 4'b1111;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("frz_noready_%0d", k), 32'(req_ready), 32'h0);
      chk($sformatf("frz_norsp_%0d", k), 32'(rsp_valid), 32'h0);
      chk($sformatf("frz_busy_%0d", k), 32'(busy), 32'h1);
      tick();
    end
    ap_ce = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("frz_ptr_kept", 32'(req_ready), 32'h4);
    chk("frz_t4_norsp", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = '0;
    chk("frz_t5_rspv", 32'(rsp_valid), 32'h2);
    chk("frz_t5_rspd", 32'(rsp_data), 32'd21);
    tick();
    chk("frz_t6_rspv", 32'(rsp_valid), 32'h4);
    chk("frz_t6_rspd", 32'(rsp_data), 32'(22'h3FFFFB));
    tick();

    // reset mid-flight: ptr=3, requester 1 granted, then reset
    set_req(1, 16'sd9, 6'sd9);
    req_valid = 4'b0010;
    #1;
    chk("rmf_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rmf_norsp_%0d", k), 32'(rsp_valid), 32'h0);
      chk($sformatf("rmf_busy_%0d", k), 32'(busy), 32'h0);
      tick();
    end
    req_valid = 4'b0011;
    #1;
    chk("rmf_ptr0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
